// File: rtl/mag_req_arbiter_if.sv
// rtl/mag_req_arbiter_if.sv - request, shared-unit and response signal bundle for mag_req_arbiter
interface mag_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_x;
  logic [8*NUM_REQ-1:0] req_y;
  logic                 mag_start;
  logic [7:0]           mag_x;
  logic [7:0]           mag_y;
  logic [7:0]           mag_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_data;

  modport slave (
    input  req_valid, req_x, req_y, mag_result, rsp_ready,
    output req_ready, mag_start, mag_x, mag_y, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_x, req_y, mag_result, rsp_ready,
    input  req_ready, mag_start, mag_x, mag_y, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mag_req_arbiter.sv
// rtl/mag_req_arbiter.sv - round-robin sequencer sharing one magnitude unit; MAG_ARB_GRANT_CNT_EN adds grant_cnt
module mag_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAG_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
`ifdef MAG_ARB_GRANT_CNT_EN
  output logic [15:0]             grant_cnt,
`endif
  mag_req_arbiter_if.slave        bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      mag_x_q, mag_x_d;
  logic [7:0]      mag_y_q, mag_y_d;
  logic            mag_start_q, mag_start_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
`ifdef MAG_ARB_GRANT_CNT_EN
  logic [15:0]     grant_cnt_q, grant_cnt_d;
`endif

  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] grant;
  logic            found;
  logic            accept;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    cand  = '0;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign accept = (state_q == IDLE) && ena && found;

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready = NUM_REQ'(1) << grant;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    mag_x_d      = mag_x_q;
    mag_y_d      = mag_y_q;
    mag_start_d  = 1'b0;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
`ifdef MAG_ARB_GRANT_CNT_EN
    grant_cnt_d  = grant_cnt_q;
    if (accept && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          mag_x_d      = bus.req_x[{grant, 3'b000} +: 8];
          mag_y_d      = bus.req_y[{grant, 3'b000} +: 8];
          id_d         = grant;
          last_grant_d = grant;
          mag_start_d  = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 3'(MAG_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // The unit's output is only meaningful in the last wait cycle.
        if (cnt_q == 3'd1) begin
          rsp_data_d  = bus.mag_result;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      mag_x_q      <= '0;
      mag_y_q      <= '0;
      mag_start_q  <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
`ifdef MAG_ARB_GRANT_CNT_EN
      grant_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      mag_x_q      <= mag_x_d;
      mag_y_q      <= mag_y_d;
      mag_start_q  <= mag_start_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
`ifdef MAG_ARB_GRANT_CNT_EN
      grant_cnt_q  <= grant_cnt_d;
`endif
    end
  end

  assign bus.mag_start = mag_start_q;
  assign bus.mag_x     = mag_x_q;
  assign bus.mag_y     = mag_y_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef MAG_ARB_GRANT_CNT_EN
  assign grant_cnt     = grant_cnt_q;
`endif
endmodule

// File: tb/tb_mag_req_arbiter.sv
// tb/tb_mag_req_arbiter.sv - randomized scoreboard bench for mag_req_arbiter
module tb_mag_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int MAG_LAT = 3;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  mag_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
`ifdef MAG_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt;
`endif

  mag_req_arbiter #(.NUM_REQ(NUM_REQ), .MAG_LAT(MAG_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
`ifdef MAG_ARB_GRANT_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .bus       (bus)
  );

  function automatic logic [7:0] mag_ref(input logic [7:0] x, input logic [7:0] y);
    int mx;
    int mn;
    mx = (x > y) ? int'(x) : int'(y);
    mn = (x > y) ? int'(y) : int'(x);
    return 8'(mx + mn / 2 - 1);
  endfunction

  // Shared unit stand-in: correct value only MAG_LAT cycles after a start, garbage otherwise.
  logic [7:0] pipe [MAG_LAT];
  always @(posedge clk) begin
    pipe[0] <= bus.mag_start ? mag_ref(bus.mag_x, bus.mag_y)
                             : mag_ref(bus.mag_x, bus.mag_y) ^ 8'($urandom_range(1, 255));
    for (int i = 1; i < MAG_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mag_result = pipe[MAG_LAT-1];

  typedef struct {
    int         id;
    logic [7:0] data;
    int         acc;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit                 busy = 1'b0;
  bit                 rst_seen = 1'b0;
  int                 acc_c = 0;
  int                 last_g = NUM_REQ - 1;
  logic [7:0]         ex, ey;
  logic [NUM_REQ-1:0] took = '0;
`ifdef MAG_ARB_GRANT_CNT_EN
  int                 gcnt = 0;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [8*NUM_REQ-1:0] v, input int i);
    return 8'(v >> (8 * i));
  endfunction

  // Round-robin rule: first valid requester after the previous winner, wrapping.
  function automatic int pick(input int last, input logic [NUM_REQ-1:0] v);
    int order[$];
    for (int k = 1; k <= NUM_REQ; k++) order.push_back((last + k) % NUM_REQ);
    foreach (order[j]) if (((v >> order[j]) & NUM_REQ'(1)) != 0) return order[j];
    return -1;
  endfunction

  task automatic model_check();
    logic [NUM_REQ-1:0] exp_rdy;
    bit                 was_busy;
    int                 g;
    exp_rdy  = '0;
    took     = '0;
    was_busy = busy;
    if (rst) begin
      busy     = 1'b0;
      last_g   = NUM_REQ - 1;
      rst_seen = 1'b1;
      exp_q.delete();
`ifdef MAG_ARB_GRANT_CNT_EN
      gcnt = 0;
`endif
      return;
    end
    if (rst_seen) begin
      check("reset_rsp_valid", int'(bus.rsp_valid), 0);
      check("reset_rsp_data", int'(bus.rsp_data), 0);
      check("reset_rsp_id", int'(bus.rsp_id), 0);
      check("reset_mag_start", int'(bus.mag_start), 0);
      check("reset_mag_x", int'(bus.mag_x), 0);
      check("reset_mag_y", int'(bus.mag_y), 0);
      rst_seen = 1'b0;
    end
    check("mag_start", int'(bus.mag_start), int'(was_busy && cyc == acc_c + 1));
    if (was_busy && cyc >= acc_c + 1 && cyc <= acc_c + 1 + MAG_LAT) begin
      check("mag_x_stable", int'(bus.mag_x), int'(ex));
      check("mag_y_stable", int'(bus.mag_y), int'(ey));
    end
`ifdef MAG_ARB_GRANT_CNT_EN
    check("grant_cnt", int'(grant_cnt), gcnt);
`endif
    if (!was_busy) begin
      if (ena && bus.req_valid != '0) begin
        g = pick(last_g, bus.req_valid);
        exp_rdy[g] = 1'b1;
        ex = byte_of(bus.req_x, g);
        ey = byte_of(bus.req_y, g);
        exp_q.push_back('{g, mag_ref(ex, ey), cyc});
        busy    = 1'b1;
        acc_c   = cyc;
        last_g  = g;
        took[g] = 1'b1;
`ifdef MAG_ARB_GRANT_CNT_EN
        if (gcnt < 65535) gcnt++;
`endif
      end
    end else if (cyc >= acc_c + MAG_LAT + 2 && bus.rsp_ready) begin
      busy = 1'b0;
    end
    check("req_ready", int'(bus.req_ready), int'(exp_rdy));
  endtask

  task automatic drive(input int p_new, input int p_drop, input int rdy_pct,
                       input int en_mode, input bit rst_v);
    bit dropped;
    rst = rst_v;
    for (int i = 0; i < NUM_REQ; i++) begin
      dropped = 1'b0;
      if (took[i]) begin
        bus.req_valid[i] = 1'b0;
      end else if (bus.req_valid[i] && int'($urandom_range(0, 99)) < p_drop) begin
        bus.req_valid[i] = 1'b0;
        dropped = 1'b1;
      end
      if (!bus.req_valid[i] && !dropped && int'($urandom_range(0, 99)) < p_new) begin
        bus.req_valid[i]     = 1'b1;
        bus.req_x[8*i +: 8]  = 8'($urandom);
        bus.req_y[8*i +: 8]  = 8'($urandom);
      end
    end
    bus.rsp_ready = int'($urandom_range(0, 99)) < rdy_pct;
    ena = (en_mode == 2) ? ($urandom_range(0, 3) != 0) : (en_mode == 1);
  endtask

  task automatic step(input int p_new, input int p_drop, input int rdy_pct,
                      input int en_mode, input bit rst_v);
    drive(p_new, p_drop, rdy_pct, en_mode, rst_v);
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y);
    bus.req_valid[i]    = 1'b1;
    bus.req_x[8*i +: 8] = x;
    bus.req_y[8*i +: 8] = y;
    took[i]             = 1'b0;
  endtask

  // Response monitor: pops the oldest expectation when a new response shows up.
  initial begin
    exp_t cur;
    bit   have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have = 1'b0;
      end else if (bus.rsp_valid) begin
        if (!have) begin
          if (exp_q.size() == 0) begin
            check("rsp_valid_unexpected", int'(bus.rsp_valid), 0);
          end else begin
            cur  = exp_q.pop_front();
            have = 1'b1;
            check("rsp_id", int'(bus.rsp_id), cur.id);
            check("rsp_data", int'(bus.rsp_data), int'(cur.data));
            check("rsp_latency", cyc - cur.acc, MAG_LAT + 2);
          end
        end else begin
          check("rsp_id_hold", int'(bus.rsp_id), cur.id);
          check("rsp_data_hold", int'(bus.rsp_data), int'(cur.data));
        end
        if (bus.rsp_ready) have = 1'b0;
      end else begin
        if (have) begin
          check("rsp_valid_hold", int'(bus.rsp_valid), 1);
          have = 1'b0;
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].acc + MAG_LAT + 2) begin
          check("rsp_valid_at_due", int'(bus.rsp_valid), 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(0, 0, 100, 0, 1'b1);
    repeat (2) step(0, 0, 100, 0, 1'b0);

    set_req(0, 8'd100, 8'd40);
    repeat (10) step(0, 0, 100, 1, 1'b0);

    repeat (30) step(100, 0, 100, 1, 1'b0);
    repeat (30) step(0, 0, 100, 1, 1'b0);

    set_req(0, 8'd7, 8'd9);
    set_req(1, 8'd50, 8'd60);
    repeat (14) step(0, 0, 0, 1, 1'b0);
    repeat (16) step(0, 0, 100, 1, 1'b0);

    set_req(3, 8'd10, 8'd200);
    repeat (12) step(0, 0, 100, 1, 1'b0);

    set_req(0, 8'd0, 8'd0);
    repeat (10) step(0, 0, 100, 0, 1'b0);
    repeat (2) step(0, 0, 100, 1, 1'b0);
    repeat (10) step(0, 0, 100, 2, 1'b0);

    set_req(2, 8'd33, 8'd44);
    repeat (3) step(0, 0, 100, 1, 1'b0);
    step(0, 0, 100, 1, 1'b1);
    set_req(0, 8'd1, 8'd2);
    set_req(3, 8'd3, 8'd4);
    repeat (20) step(0, 0, 100, 1, 1'b0);

    repeat (2000) step(30, 5, 70, 2, $urandom_range(0, 299) == 0);

    repeat (60) step(0, 0, 100, 1, 1'b0);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_model_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mag_req_arbiter.md
Name: mag_req_arbiter

Overview:
Round-robin arbiter and sequencer sharing one registered magnitude-approximation unit (|v| ≈ max + min/2 − 1, 8-bit) among NUM_REQ requesters. Accepts one request at a time over valid/ready, drives the shared unit's operand/start port, and captures its result after MAG_LAT cycles. Returns the result on a single tagged response channel. Sits between the sensor-side requesters and the magnitude datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ), derived.
MAG_LAT, 1, cycles from mag_start to a valid mag_result (1..7).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ena  in  1  grant enable; low blocks new grants, in-flight op completes
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_x  in  8*NUM_REQ  X operand, requester i at [8i+7:8i]
req_y  in  8*NUM_REQ  Y operand, same packing
mag_start  out  1  one-cycle start pulse to shared unit
mag_x  out  8  operand X to shared unit
mag_y  out  8  operand Y to shared unit
mag_result  in  8  shared unit output
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of requester that issued the op
rsp_data  out  8  captured magnitude

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, mag_start=0, mag_x=mag_y=0, wait counter=0, last_grant=NUM_REQ−1 (requester 0 wins first). Takes priority over all other activity; an in-flight op is abandoned with no response and its mag_result ignored.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if ena=1 and any req_valid, grant = first valid index scanning last_grant+1, +2, ... mod NUM_REQ. req_ready[grant]=1 combinationally this cycle (all other bits 0). On the edge: latch req_x/req_y of grant into mag_x/mag_y, latch grant into id register and last_grant, go ISSUE. If ena=0 or none valid: req_ready=0, stay.
- req_ready is 0 in every state except IDLE. Requesters hold valid and operands until accepted. Deassertion before acceptance is legal; no grant is given.
- ISSUE: mag_start=1 for exactly this cycle, mag_x/mag_y stable. Load counter=MAG_LAT. Go WAIT.
- WAIT: mag_x/mag_y held stable. Counter decrements each cycle. In the cycle where counter==1, mag_result is valid: capture it into rsp_data and id into rsp_id, set rsp_valid, go RESP. With MAG_LAT=1, WAIT lasts 1 cycle.
- RESP: rsp_valid=1; rsp_data and rsp_id held stable. On an edge with rsp_ready=1: rsp_valid->0, go IDLE.
- Throughput: one op per MAG_LAT+3 cycles minimum. Latency from acceptance to rsp_valid: MAG_LAT+2 cycles.
- No arithmetic in this block. rsp_data is the unit's 8-bit output passed through unmodified, including wrap (x=y=0 gives 255).
- ena changes outside IDLE have no effect on the current op.

Optional Feature:
MAG_ARB_GRANT_CNT_EN: adds output grant_cnt [15:0]. It is reset to 0 and increments on each IDLE acceptance, saturating at 16'hFFFF (no wrap). It increments in the same edge as the latch. Without the macro, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Single op, MAG_LAT=1: req0 x=100, y=40 -> req_ready[0] pulse 1 cycle; mag_start 1 cycle with mag_x=100, mag_y=40; rsp_valid 3 cycles after accept, rsp_id=0, rsp_data=119.
- Round robin: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0. Then with only req2 and req0 valid after last grant 0 -> req2 granted next.
- Backpressure: rsp_ready=0 for 5 cycles with req1 pending -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 0. After rsp_ready=1, req1 is accepted the cycle after return to IDLE.
- MAG_LAT=3: req3 x=10, y=200 -> rsp_valid exactly 5 cycles after accept, rsp_data=204, mag_x/mag_y stable throughout WAIT.
- Reset mid-WAIT: assert rst 1 cycle -> next cycle all outputs at reset values, no rsp_valid. Requester 0 granted first afterward. Wrap case: x=y=0 -> rsp_data=255.
- ena=0 with req0 valid -> no req_ready for 10 cycles. ena raised during WAIT does not disturb the op. With MAG_ARB_GRANT_CNT_EN: grant_cnt counts 5 after 5 ops and stays 0 while ena=0.
